alert_tx: RTL and testbench

- Consumer end of the 256-cycle alert frame.
- On each trans_enable pulse, latches a parallel word and serializes it on tx_out as start / data (LSB first) / optional parity / stop.
- On each test_enable pulse, reports whether the frame completed cleanly.
- Tracks pulse health: overrun and missed-period errors. Sits beside the alert generator, on the sysclk domain.

---
 rtl/alert_pkg.sv | 16 +
 rtl/alert_watchdog.sv | 32 +++
 rtl/alert_tx.sv | 138 +++++++++++++
 tb/tb_alert_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alert_pkg.sv
// Shared definitions for the alert frame generator/consumer pair.
package alert_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int ALERT_PERIOD = 256;
  localparam int TRANS_SLOT   = 128;
  localparam int TEST_SLOT    = 144;

endpackage

// File: rtl/alert_watchdog.sv
// Missed-period detector: counts sysclk cycles between trans_enable pulses once armed.
module alert_watchdog
  import alert_pkg::*;
#(
  parameter int PERIOD = ALERT_PERIOD
) (
  input  logic sysclk,
  input  logic reset,
  input  logic trans_enable,
  input  logic accepted,
  output logic miss_err
);

  logic [8:0] cnt_p0;
  logic       armed_p0;

  // A pulse exactly PERIOD cycles after the previous one arrives while cnt is PERIOD-1.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_p0   <= '0;
      armed_p0 <= 1'b0;
      miss_err <= 1'b0;
    end else if (trans_enable) begin
      cnt_p0 <= '0;
      if (accepted) armed_p0 <= 1'b1;
    end else if (armed_p0) begin
      if (cnt_p0 != 9'(PERIOD)) cnt_p0 <= cnt_p0 + 9'd1;
      if (cnt_p0 == 9'(PERIOD - 1)) miss_err <= 1'b1;
    end
  end

endmodule

// File: rtl/alert_tx.sv
// Serializes a latched payload as start/data(LSB first)/[parity]/stop on tx_out.
// Optional even-parity bit enabled by defining PARITY_EN.
module alert_tx
  import alert_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 1,
  parameter int PERIOD  = ALERT_PERIOD
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              trans_enable,
  input  logic              test_enable,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              test_ok,
  output logic              overrun_err,
  output logic              miss_err,
  output logic [7:0]        frame_cnt
);

  state_e            state_p0, state_nxt;
  logic [1:0]        cyc_p0, cyc_nxt;
  logic [3:0]        idx_p0, idx_nxt;
  logic [DATA_W-1:0] sh_p0, sh_nxt;
  logic              done_seen_p0;
  logic              bit_end, last_bit, accept, done_ev, par_bit;
  logic              tx_d, busy_d;

  assign bit_end  = (cyc_p0 == 2'(BIT_CYC - 1));
  assign last_bit = (idx_p0 == 4'(DATA_W - 1));
  assign accept   = trans_enable && (state_p0 == IDLE);
  assign done_ev  = (state_p0 == STOP) && bit_end;

`ifdef PARITY_EN
  logic par_p0;
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)      par_p0 <= 1'b0;
    else if (accept) par_p0 <= ^data_in;
  end
  assign par_bit = par_p0;
`else
  assign par_bit = 1'b1;
`endif

  // Stage p0: FSM state, bit timing and shift register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      cyc_p0   <= '0;
      idx_p0   <= '0;
      sh_p0    <= '0;
    end else begin
      state_p0 <= state_nxt;
      cyc_p0   <= cyc_nxt;
      idx_p0   <= idx_nxt;
      sh_p0    <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    cyc_nxt   = bit_end ? 2'd0 : cyc_p0 + 2'd1;
    idx_nxt   = idx_p0;
    sh_nxt    = sh_p0;
    case (state_p0)
      IDLE: begin
        cyc_nxt = '0;
        if (trans_enable) begin
          state_nxt = START;
          sh_nxt    = data_in;
          idx_nxt   = '0;
        end
      end
      START:  if (bit_end) state_nxt = DATA;
      DATA: begin
        if (bit_end) begin
          sh_nxt  = sh_p0 >> 1;
          idx_nxt = idx_p0 + 4'd1;
`ifdef PARITY_EN
          if (last_bit) state_nxt = PARITY;
`else
          if (last_bit) state_nxt = STOP;
`endif
        end
      end
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered line lines up with state_p0.
  always_comb begin
    busy_d = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_nxt[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  // Stage p1: registered outputs and frame bookkeeping
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_out       <= 1'b1;
      tx_busy      <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      test_ok      <= 1'b0;
      overrun_err  <= 1'b0;
      done_seen_p0 <= 1'b0;
    end else begin
      tx_out     <= tx_d;
      tx_busy    <= busy_d;
      frame_done <= done_ev;
      if (done_ev) frame_cnt <= frame_cnt + 8'd1;
      if (test_enable) test_ok <= !tx_busy && done_seen_p0;
      if (trans_enable && (state_p0 != IDLE)) overrun_err <= 1'b1;
      if (accept)       done_seen_p0 <= 1'b0;
      else if (done_ev) done_seen_p0 <= 1'b1;
    end
  end

  alert_watchdog #(
    .PERIOD(PERIOD)
  ) u_watchdog (
    .sysclk      (sysclk),
    .reset       (reset),
    .trans_enable(trans_enable),
    .accepted    (accept),
    .miss_err    (miss_err)
  );

endmodule

// File: tb/tb_alert_tx.sv
// Directed bench for alert_tx: frame serialization, test_ok, overrun, watchdog, async reset.
module tb_alert_tx;

  localparam int DW = 8;
`ifdef PARITY_EN
  localparam int L = DW + 3;
`else
  localparam int L = DW + 2;
`endif

  logic          sysclk = 1'b0;
  logic          reset = 1'b0;
  logic          trans_enable = 1'b0;
  logic          test_enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          tx_out, tx_busy, frame_done, test_ok, overrun_err, miss_err;
  logic [7:0]    frame_cnt;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic exp_q[$];

  always #5 sysclk = ~sysclk;

  alert_tx #(
    .DATA_W (DW),
    .BIT_CYC(1),
    .PERIOD (alert_pkg::ALERT_PERIOD)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .trans_enable(trans_enable),
    .test_enable (test_enable),
    .data_in     (data_in),
    .tx_out      (tx_out),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .test_ok     (test_ok),
    .overrun_err (overrun_err),
    .miss_err    (miss_err),
    .frame_cnt   (frame_cnt)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [DW-1:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`ifdef PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Starts a frame in the current cycle and checks every line cycle against the queue.
  task automatic run_frame(input logic [DW-1:0] d, input int test_i, input int ovr_i,
                           input logic [7:0] cnt_exp);
    logic b;
    trans_enable = 1'b1;
    data_in      = d;
    push_frame(d);
    tick();
    trans_enable = 1'b0;
    test_enable  = 1'b0;
    data_in      = ~d;
    for (int i = 0; i < L; i++) begin
      if (i == test_i + 1) chk("test_ok_inflight", test_ok, 0);
      if (i == ovr_i + 1) chk("overrun_err_set", overrun_err, 1);
      b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      chk("tx_out_bit", tx_out, b);
      chk("tx_busy_inflight", tx_busy, 1);
      chk("frame_done_inflight", frame_done, 0);
      if (i == test_i) test_enable = 1'b1;
      if (i == ovr_i) begin
        trans_enable = 1'b1;
        data_in      = 8'hFF;
      end
      tick();
      test_enable  = 1'b0;
      trans_enable = 1'b0;
    end
    chk("frame_done_pulse", frame_done, 1);
    chk("tx_busy_end", tx_busy, 0);
    chk("tx_out_idle", tx_out, 1);
    chk("frame_cnt", frame_cnt, cnt_exp);
    chk("queue_drained", 16'(exp_q.size()), 0);
    tick();
    chk("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_test_ok", test_ok, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_miss", miss_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b1;
    cyc   = 0;

    goto(alert_pkg::TRANS_SLOT);
    run_frame(8'hA5, -10, -10, 8'd1);
    goto(alert_pkg::TEST_SLOT);
    test_enable = 1'b1;
    tick();
    test_enable = 1'b0;
    chk("test_ok_clean", test_ok, 1);

    goto(alert_pkg::TRANS_SLOT + alert_pkg::ALERT_PERIOD);
    chk("miss_before_ontime", miss_err, 0);
    run_frame(8'h01, 2, -10, 8'd2);
    chk("miss_after_ontime", miss_err, 0);
    goto(400);
    test_enable = 1'b1;
    tick();
    test_enable = 1'b0;
    chk("test_ok_second", test_ok, 1);

    goto(640);
    chk("miss_at_period_minus1", miss_err, 0);
    tick();
    chk("miss_set", miss_err, 1);
    goto(660);
    chk("miss_sticky", miss_err, 1);

    goto(700);
    test_enable = 1'b1;
    run_frame(8'h5A, -10, 4, 8'd3);
    chk("test_ok_simultaneous", test_ok, 1);
    chk("overrun_sticky", overrun_err, 1);

    goto(800);
    rd           = 8'h3C;
    trans_enable = 1'b1;
    data_in      = rd;
    tick();
    trans_enable = 1'b0;
    chk("rst_frame_start", tx_out, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_frame_bit", tx_out, rd[i]);
    end
    reset = 1'b0;
    #1;
    chk("midrst_tx_out", tx_out, 1);
    chk("midrst_tx_busy", tx_busy, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_overrun", overrun_err, 0);
    chk("midrst_miss", miss_err, 0);
    chk("midrst_test_ok", test_ok, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_rst_idle_line", tx_out, 1);
    chk("post_rst_idle_busy", tx_busy, 0);
    run_frame(8'hC3, -10, -10, 8'd1);
    test_enable = 1'b1;
    tick();
    test_enable = 1'b0;
    chk("test_ok_after_reset", test_ok, 1);
    chk("overrun_after_reset", overrun_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
